// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial request path: opcodes, packet/error
// field positions and the CRC-4 used by the receiver and the stimulus side.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101
   } operation_t;

   localparam logic PKT_DATA = 1'b0;
   localparam logic PKT_CMD  = 1'b1;

   localparam int unsigned ERR_DATA_BIT = 2;
   localparam int unsigned ERR_CRC_BIT  = 1;
   localparam int unsigned ERR_OP_BIT   = 0;

   // x^4+x+1, message consumed MSB first, starting from crc value c
   function automatic bit [3:0] alu_crc4(input bit [67:0] d, input bit [3:0] c);
      bit [3:0] r;
      bit       fb;
      r = c;
      for (int unsigned i = 0; i < 68; i++) begin
         fb = d[67-i] ^ r[3];
         r  = {r[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_serial_rx_if.sv
// Serial request line plus the decoded frame presented to the ALU core.
interface alu_serial_rx_if;
   logic        sin;
   logic        out_valid;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_op;
   logic [2:0]  out_err;
   logic        busy;

   modport master (output sin, input out_valid, out_a, out_b, out_op, out_err, busy);
   modport slave  (input sin, output out_valid, out_a, out_b, out_op, out_err, busy);
endinterface

// File: rtl/alu_pkt_shifter.sv
// Collects the type and payload bits of one packet after its start bit;
// pkt_done flags the stop-bit cycle, with stop_ok taken directly from sin.
module alu_pkt_shifter #(
   parameter int unsigned PKT_BITS = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   input  logic       start,
   input  logic       run,
   output logic       pkt_done,
   output logic       pkt_type,
   output logic [7:0] pkt_payload,
   output logic       stop_ok
);
   localparam int unsigned CW = $clog2(PKT_BITS);

   logic [CW-1:0]       bit_cnt;
   logic [PKT_BITS-3:0] sr;

   assign pkt_done    = run && (bit_cnt == CW'(PKT_BITS - 1));
   assign pkt_type    = sr[PKT_BITS-3];
   assign pkt_payload = sr[7:0];
   assign stop_ok     = sin;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         sr      <= '0;
      end else if (start) begin
         bit_cnt <= CW'(1);
      end else if (run) begin
         sr      <= {sr[PKT_BITS-4:0], sin};
         bit_cnt <= pkt_done ? '0 : bit_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/alu_serial_rx.sv
// Frame receiver: assembles B then A from data packets, validates the
// closing CMD packet and pulses out_valid with operands and error flags.
module alu_serial_rx
   import alu_pkg::*;
#(
   parameter int unsigned DATA_PKTS = 8,
   parameter int unsigned PKT_BITS  = 11
) (
   input logic             clk,
   input logic             rst,
   alu_serial_rx_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DATA_PKTS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_PKTS);

   typedef enum logic [1:0] {S_IDLE, S_PKT, S_DONE} rx_state_t;

   rx_state_t              state, state_n;
   logic [CNT_W-1:0]       byte_cnt;
   logic                   data_err;
   logic [8*DATA_PKTS-1:0] ab;
   logic                   start, store_byte, set_derr, frame_done;
   logic                   pkt_done, pkt_type, stop_ok;
   logic [7:0]             pkt_payload;
   logic [2:0]             cmd_op, err_n;
   logic [3:0]             cmd_crc;
   logic                   valid_q, busy_q;
   logic [31:0]            a_q, b_q;
   logic [2:0]             op_q, err_q;

   alu_pkt_shifter #(.PKT_BITS(PKT_BITS)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .sin        (bus.sin),
      .start      (start),
      .run        (state == S_PKT),
      .pkt_done   (pkt_done),
      .pkt_type   (pkt_type),
      .pkt_payload(pkt_payload),
      .stop_ok    (stop_ok)
   );

   assign cmd_op  = pkt_payload[6:4];
   assign cmd_crc = pkt_payload[3:0];

   // Packet classification happens in the stop-bit cycle itself, so there is
   // no registered CHECK state: PKT branches straight to IDLE or DONE.
   always_comb begin
      state_n    = state;
      start      = 1'b0;
      store_byte = 1'b0;
      set_derr   = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: if (!bus.sin) begin
            start   = 1'b1;
            state_n = S_PKT;
         end
         S_PKT: if (pkt_done) begin
            set_derr = !stop_ok;
            if (pkt_type == PKT_CMD) begin
               frame_done = 1'b1;
               state_n    = S_DONE;
            end else begin
               state_n = S_IDLE;
               if (byte_cnt < FULL_CNT) store_byte = 1'b1;
               else                     set_derr   = 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      err_n = '0;
      if (data_err || !stop_ok || byte_cnt != FULL_CNT)
         err_n[ERR_DATA_BIT] = 1'b1;
      else if (alu_crc4({ab, 1'b1, cmd_op}, 4'h0) != cmd_crc)
         err_n[ERR_CRC_BIT] = 1'b1;
      else if (!(cmd_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB}))
         err_n[ERR_OP_BIT] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         data_err <= 1'b0;
         ab       <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         err_q    <= '0;
      end else begin
         state   <= state_n;
         valid_q <= frame_done;
         if (start) busy_q <= 1'b1;
         if (store_byte) begin
            ab       <= {ab[8*DATA_PKTS-9:0], pkt_payload};
            byte_cnt <= byte_cnt + CNT_W'(1);
         end
         if (set_derr) data_err <= 1'b1;
         if (frame_done) begin
            a_q   <= ab[31:0];
            b_q   <= ab[63:32];
            op_q  <= cmd_op;
            err_q <= err_n;
         end
         if (state == S_DONE) begin
            busy_q   <= 1'b0;
            byte_cnt <= '0;
            data_err <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_a     = a_q;
   assign bus.out_b     = b_q;
   assign bus.out_op    = op_q;
   assign bus.out_err   = err_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed frame-level bench for alu_serial_rx with hand-computed expectations.
module tb_alu_serial_rx;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_serial_rx_if bus();

   alu_serial_rx #(.DATA_PKTS(8), .PKT_BITS(11)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int unsigned n_chk = 0, n_err = 0, vseen = 0, busy_low = 0, v0;
   logic [31:0] cap_a, cap_b;
   logic [2:0]  cap_op, cap_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bit period: sample outputs away from the clock edge, then drive sin.
   task automatic tick(input logic b);
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
         vseen++;
         cap_a   = bus.out_a;
         cap_b   = bus.out_b;
         cap_op  = bus.out_op;
         cap_err = bus.out_err;
      end
      bus.sin = b;
   endtask

   task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop,
                           input int unsigned gap);
      logic [10:0] p;
      p = {1'b0, typ, pl, stop};
      for (int unsigned i = 0; i < 11; i++) tick(p[10-i]);
      for (int unsigned i = 0; i < gap; i++) begin
         tick(1'b1);
         if (bus.busy !== 1'b1) busy_low++;
      end
   endtask

   task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                             input logic [3:0] crc, input int unsigned gap);
      for (int unsigned i = 0; i < 4; i++) send_pkt(PKT_DATA, b[31-8*i -: 8], 1'b1, gap);
      for (int unsigned i = 0; i < 4; i++) send_pkt(PKT_DATA, a[31-8*i -: 8], 1'b1, gap);
      send_pkt(PKT_CMD, {1'b0, op, crc}, 1'b1, 0);
   endtask

   // Valid must appear exactly in the cycle after the CMD stop bit, for one cycle.
   task automatic wait_done(input string tag, input int unsigned v_before);
      check_eq({tag, " early"}, vseen, v_before);
      tick(1'b1);
      check_eq({tag, " latency"}, vseen, v_before + 1);
      tick(1'b1);
      check_eq({tag, " pulse"}, vseen, v_before + 1);
      check_eq({tag, " busy"}, bus.busy, 0);
   endtask

   initial begin
      logic [31:0] b3, a3;
      rst     = 1'b1;
      bus.sin = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst valid", bus.out_valid, 0);
      check_eq("rst a", bus.out_a, 0);
      check_eq("rst b", bus.out_b, 0);
      check_eq("rst op", bus.out_op, 0);
      check_eq("rst err", bus.out_err, 0);
      check_eq("rst busy", bus.busy, 0);
      rst = 1'b0;
      repeat (2) tick(1'b1);

      // all-zero AND frame, CRC 1011
      v0 = vseen;
      send_frame(32'h0, 32'h0, 3'b000, 4'b1011, 0);
      wait_done("t1", v0);
      check_eq("t1 a", cap_a, 32'h0);
      check_eq("t1 b", cap_b, 32'h0);
      check_eq("t1 op", cap_op, 3'b000);
      check_eq("t1 err", cap_err, 3'b000);

      // same frame, wrong CRC
      v0 = vseen;
      send_frame(32'h0, 32'h0, 3'b000, 4'b1100, 0);
      wait_done("t2", v0);
      check_eq("t2 err", cap_err, 3'b010);

      // good CRC, illegal opcode 011
      b3 = 32'hFFFF_FFFF;
      a3 = 32'h1234_5678;
      v0 = vseen;
      send_frame(b3, a3, 3'b011, alu_crc4({b3, a3, 1'b1, 3'b011}, 4'h0), 0);
      wait_done("t3", v0);
      check_eq("t3 err", cap_err, 3'b001);
      check_eq("t3 a", cap_a, 32'h1234_5678);
      check_eq("t3 b", cap_b, 32'hFFFF_FFFF);
      check_eq("t3 op", cap_op, 3'b011);

      // 7 data packets, then two CMD packets
      v0 = vseen;
      for (int unsigned i = 0; i < 7; i++) send_pkt(PKT_DATA, 8'(8'h11 * i), 1'b1, 0);
      send_pkt(PKT_CMD, 8'b0100_0000, 1'b1, 0);
      wait_done("t4a", v0);
      check_eq("t4a err", cap_err, 3'b100);
      v0 = vseen;
      send_pkt(PKT_CMD, 8'b0100_0000, 1'b1, 0);
      wait_done("t4b", v0);
      check_eq("t4b err", cap_err, 3'b100);

      // ADD with 5 idle cycles after every data packet
      v0 = vseen;
      send_frame(32'd1, 32'd2, 3'b100, alu_crc4({32'd1, 32'd2, 1'b1, 3'b100}, 4'h0), 5);
      wait_done("t5", v0);
      check_eq("t5 err", cap_err, 3'b000);
      check_eq("t5 a", cap_a, 32'd2);
      check_eq("t5 b", cap_b, 32'd1);
      check_eq("t5 op", cap_op, 3'b100);
      check_eq("t5 gap busy low", busy_low, 0);

      // stop bit 0 on the third data packet of an otherwise good frame
      v0 = vseen;
      send_pkt(PKT_DATA, 8'h00, 1'b1, 0);
      send_pkt(PKT_DATA, 8'h00, 1'b1, 0);
      send_pkt(PKT_DATA, 8'h00, 1'b0, 0);
      for (int unsigned i = 0; i < 5; i++) send_pkt(PKT_DATA, 8'h00, 1'b1, 0);
      send_pkt(PKT_CMD, {1'b0, 3'b000, 4'b1011}, 1'b1, 0);
      wait_done("t6", v0);
      check_eq("t6 err", cap_err, 3'b100);

      // nine data packets: counter saturates, ninth byte dropped
      b3 = 32'hA1A2_A3A4;
      a3 = 32'hB1B2_B3B4;
      v0 = vseen;
      for (int unsigned i = 0; i < 4; i++) send_pkt(PKT_DATA, b3[31-8*i -: 8], 1'b1, 0);
      for (int unsigned i = 0; i < 4; i++) send_pkt(PKT_DATA, a3[31-8*i -: 8], 1'b1, 0);
      send_pkt(PKT_DATA, 8'hCC, 1'b1, 0);
      send_pkt(PKT_CMD, 8'b0100_0000, 1'b1, 0);
      wait_done("t7", v0);
      check_eq("t7 err", cap_err, 3'b100);
      check_eq("t7 a", cap_a, 32'hB1B2_B3B4);
      check_eq("t7 b", cap_b, 32'hA1A2_A3A4);

      // reset in the middle of the fifth data packet, then a clean SUB frame
      v0 = vseen;
      for (int unsigned i = 0; i < 4; i++) send_pkt(PKT_DATA, 8'h5A, 1'b1, 0);
      tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
      rst = 1'b1;
      tick(1'b1);
      rst = 1'b0;
      repeat (3) tick(1'b1);
      check_eq("t8 busy after rst", bus.busy, 0);
      send_frame(32'd7, 32'd9, 3'b101, alu_crc4({32'd7, 32'd9, 1'b1, 3'b101}, 4'h0), 0);
      wait_done("t8", v0);
      check_eq("t8 err", cap_err, 3'b000);
      check_eq("t8 a", cap_a, 32'd9);
      check_eq("t8 b", cap_b, 32'd7);
      check_eq("t8 op", cap_op, 3'b101);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
